i2c_reg_access_seq: RTL and testbench

- Transaction sequencer sitting above i2c_master_byte_ctrl.
- Turns one host request into the full I2C register-access byte sequence on the byte-controller command interface (start/stop/read/write/ack_in/din, cmd_ack/ack_out/dout):
  - write: S, dev+W, reg, data, P
  - read: S, dev+W, reg, Sr, dev+R, data+NACK, P
- Handles slave NACK abort and a per-byte watchdog, and reports one result per request.

---
 rtl/i2c_reg_access_seq_pkg.sv | 80 ++++++++
 rtl/i2c_reg_access_seq.sv | 191 +++++++++++++++++++
 tb/tb_i2c_reg_access_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_access_seq_pkg.sv
// Shared types for the I2C register-access sequencer: FSM state encoding,
// RW-bit constants and the byte-controller command bundle.
package i2c_reg_access_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_W,
        REG,
        WDATA,
        RS_DEV,
        RDATA,
        ABORT,
        WAIT_BUS,
        DONE
    } state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } bc_cmd_t;

    localparam bc_cmd_t BC_CMD_NONE = '0;

    // Command set the byte controller sees for as long as the FSM sits in st.
    function automatic bc_cmd_t bc_cmd_for(
        input state_t     st,
        input logic [6:0] dev,
        input logic [7:0] reg_a,
        input logic [7:0] wdat
    );
        bc_cmd_t c;
        c = BC_CMD_NONE;
        case (st)
            DEV_W: begin
                c.start = 1'b1;
                c.write = 1'b1;
                c.din   = {dev, I2C_RW_WRITE};
            end
            REG: begin
                c.write = 1'b1;
                c.din   = reg_a;
            end
            WDATA: begin
                c.write = 1'b1;
                c.stop  = 1'b1;
                c.din   = wdat;
            end
            RS_DEV: begin
                c.start = 1'b1;
                c.write = 1'b1;
                c.din   = {dev, I2C_RW_READ};
            end
            RDATA: begin
                c.read   = 1'b1;
                c.stop   = 1'b1;
                c.ack_in = 1'b1;
            end
            ABORT: begin
                c.stop = 1'b1;
            end
            default: begin
                c = BC_CMD_NONE;
            end
        endcase
        return c;
    endfunction

    // States in which the per-command watchdog runs.
    function automatic logic is_timed(input state_t st);
        return (st != IDLE) && (st != DONE);
    endfunction

endpackage

// File: rtl/i2c_reg_access_seq.sv
// Register-access sequencer: expands one host read/write request into the
// byte-controller command stream, with NACK abort and a per-command watchdog.
module i2c_reg_access_seq
    import i2c_reg_access_seq_pkg::*;
#(
    parameter int TO_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rnw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err_nack,
    output logic       err_to,
    output logic       bc_start,
    output logic       bc_stop,
    output logic       bc_read,
    output logic       bc_write,
    output logic       bc_ack_in,
    output logic [7:0] bc_din,
    input  logic       bc_cmd_ack,
    input  logic       bc_ack_out,
    input  logic [7:0] bc_dout,
    input  logic       bc_busy
);

    localparam logic [TO_W-1:0] WD_ONE = TO_W'(1);
    localparam logic [TO_W-1:0] WD_TWO = TO_W'(2);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    bc_cmd_t         cmd_q, cmd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_nack_q, err_nack_d;
    logic            err_to_q, err_to_d;
    logic            rnw_q, rnw_d;
    logic [6:0]      dev_q, dev_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      wdata_q, wdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wd_q       <= '0;
            cmd_q      <= BC_CMD_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= 8'h00;
            err_nack_q <= 1'b0;
            err_to_q   <= 1'b0;
            rnw_q      <= 1'b0;
            dev_q      <= 7'h00;
            reg_q      <= 8'h00;
            wdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            cmd_q      <= cmd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            err_nack_q <= err_nack_d;
            err_to_q   <= err_to_d;
            rnw_q      <= rnw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        cmd_d      = cmd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        err_nack_d = err_nack_q;
        err_to_d   = err_to_q;
        rnw_d      = rnw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    rnw_d      = rnw;
                    dev_d      = dev_addr;
                    reg_d      = reg_addr;
                    wdata_d    = wdata;
                    busy_d     = 1'b1;
                    err_nack_d = 1'b0;
                    err_to_d   = 1'b0;
                    state_d    = DEV_W;
                end
            end
            DEV_W: begin
                if (bc_cmd_ack) begin
                    state_d = bc_ack_out ? ABORT : REG;
                end
            end
            REG: begin
                if (bc_cmd_ack) begin
                    if (bc_ack_out) begin
                        state_d = ABORT;
                    end else if (rnw_q == I2C_RW_READ) begin
                        state_d = RS_DEV;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                // The stop rides on this byte, so a data NACK needs no abort.
                if (bc_cmd_ack) begin
                    err_nack_d = bc_ack_out;
                    state_d    = WAIT_BUS;
                end
            end
            RS_DEV: begin
                if (bc_cmd_ack) begin
                    state_d = bc_ack_out ? ABORT : RDATA;
                end
            end
            RDATA: begin
                if (bc_cmd_ack) begin
                    rdata_d = bc_dout;
                    state_d = WAIT_BUS;
                end
            end
            ABORT: begin
                if (bc_cmd_ack) begin
                    state_d = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                // Give the stop two cycles to raise bc_busy before trusting it.
                if ((wd_q >= WD_TWO) && !bc_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Expiry only applies when nothing else moved the FSM this cycle.
        if (is_timed(state_q) && (state_d == state_q) && (wd_q == '1)) begin
            state_d  = DONE;
            err_to_d = 1'b1;
        end

        if (state_d != state_q) begin
            wd_d  = '0;
            cmd_d = bc_cmd_for(state_d, dev_d, reg_d, wdata_d);
            if (state_d == ABORT) begin
                err_nack_d = 1'b1;
            end
            if (state_d == DONE) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end else if (is_timed(state_q)) begin
            wd_d = wd_q + WD_ONE;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err_nack  = err_nack_q;
    assign err_to    = err_to_q;
    assign bc_start  = cmd_q.start;
    assign bc_stop   = cmd_q.stop;
    assign bc_read   = cmd_q.read;
    assign bc_write  = cmd_q.write;
    assign bc_ack_in = cmd_q.ack_in;
    assign bc_din    = cmd_q.din;

endmodule

// File: tb/tb_i2c_reg_access_seq.sv
// Scoreboard bench: byte-controller/slave model drives the DUT, a transaction-level
// reference model predicts command streams and results, a monitor checks each done.
module tb_i2c_reg_access_seq;
    import i2c_reg_access_seq_pkg::*;

    localparam int TO_W = 4;
    localparam int TO_LAT = 1 << TO_W;

    logic       clk;
    logic       rst;
    logic       req;
    logic       rnw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       err_nack;
    logic       err_to;
    logic       bc_start;
    logic       bc_stop;
    logic       bc_read;
    logic       bc_write;
    logic       bc_ack_in;
    logic [7:0] bc_din;
    logic       bc_cmd_ack;
    logic       bc_ack_out;
    logic [7:0] bc_dout;
    logic       bc_busy;

    i2c_reg_access_seq #(.TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .req(req), .rnw(rnw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .err_nack(err_nack), .err_to(err_to),
        .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read),
        .bc_write(bc_write), .bc_ack_in(bc_ack_in), .bc_din(bc_din),
        .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout),
        .bc_busy(bc_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [5:0][12:0] cmds;
        logic [2:0]       ncmd;
        logic             err_nack;
        logic             err_to;
        logic             chk_rdata;
        logic [7:0]       rdata;
        logic [7:0]       lat;
        logic             rnw;
        logic [6:0]       dev;
        logic [7:0]       reg_a;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          txn = 0;
    exp_t        sb_q[$];
    logic [12:0] cmd_log[$];
    logic [7:0]  mem[256];
    logic [7:0]  ref_mem[256];
    logic        mute;
    logic        nack_data;

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
        end
    endtask

    function automatic logic present(input logic [6:0] a);
        return (a == 7'h50) || (a == 7'h3C);
    endfunction

    // Command word as logged: {start,stop,read,write,ack_in,din}; din only matters on writes.
    function automatic logic [12:0] cw(input logic s, input logic p, input logic r,
                                       input logic w, input logic a, input logic [7:0] d);
        return {s, p, r, w, a, (w ? d : 8'h00)};
    endfunction

    // Reference model: I2C register-access protocol at transaction level.
    task automatic model_req(input logic r, input logic [6:0] d, input logic [7:0] ra,
                             input logic [7:0] wd, output exp_t e);
        e = '0;
        e.rnw   = r;
        e.dev   = d;
        e.reg_a = ra;
        if (mute) begin
            e.err_to = 1'b1;
            e.lat    = 8'(TO_LAT);
        end else if (!present(d)) begin
            e.cmds[0]  = cw(1, 0, 0, 1, 0, {d, 1'b0});
            e.cmds[1]  = cw(0, 1, 0, 0, 0, 8'h00);
            e.ncmd     = 3'd2;
            e.err_nack = 1'b1;
        end else if (!r) begin
            e.cmds[0] = cw(1, 0, 0, 1, 0, {d, 1'b0});
            e.cmds[1] = cw(0, 0, 0, 1, 0, ra);
            e.cmds[2] = cw(0, 1, 0, 1, 0, wd);
            e.ncmd    = 3'd3;
            if (nack_data) e.err_nack = 1'b1;
            else ref_mem[ra] = wd;
        end else begin
            e.cmds[0]   = cw(1, 0, 0, 1, 0, {d, 1'b0});
            e.cmds[1]   = cw(0, 0, 0, 1, 0, ra);
            e.cmds[2]   = cw(1, 0, 0, 1, 0, {d, 1'b1});
            e.cmds[3]   = cw(0, 1, 1, 0, 1, 8'h00);
            e.ncmd      = 3'd4;
            e.chk_rdata = 1'b1;
            e.rdata     = ref_mem[ra];
        end
    endtask

    // Byte-controller + slave bus-functional model.
    logic       addressed;
    logic       byte_idx;
    logic [7:0] ptr;
    logic       pending;
    int         dly;
    int         busy_cnt;

    task automatic bfm_ack();
        cmd_log.push_back(cw(bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din));
        bc_ack_out = 1'b0;
        if (bc_start) begin
            bc_busy    = 1'b1;
            busy_cnt   = 0;
            addressed  = present(bc_din[7:1]);
            byte_idx   = 1'b0;
            bc_ack_out = !addressed;
        end else if (bc_write) begin
            if (!addressed) bc_ack_out = 1'b1;
            else if (!byte_idx) begin
                ptr      = bc_din;
                byte_idx = 1'b1;
            end else if (nack_data) bc_ack_out = 1'b1;
            else mem[ptr] = bc_din;
        end
        if (bc_read) bc_dout = addressed ? mem[ptr] : 8'hFF;
        if (bc_stop) begin
            busy_cnt  = $urandom_range(1, 4);
            addressed = 1'b0;
        end
        bc_cmd_ack = 1'b1;
    endtask

    initial begin
        bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_dout = 8'h00; bc_busy = 1'b0;
        addressed = 1'b0; byte_idx = 1'b0; ptr = 8'h00; pending = 1'b0; dly = 0; busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_busy = 1'b0;
                addressed = 1'b0; pending = 1'b0; busy_cnt = 0;
                cmd_log.delete();
            end else begin
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) bc_busy = 1'b0;
                end
                if (bc_cmd_ack) begin
                    bc_cmd_ack = 1'b0;
                    bc_ack_out = 1'b0;
                end else if ((bc_start | bc_stop | bc_read | bc_write) && !mute) begin
                    if (!pending) begin
                        pending = 1'b1;
                        dly     = $urandom_range(0, 4);
                    end
                    if (dly == 0) begin
                        pending = 1'b0;
                        bfm_ack();
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    int   cyc = 0;
    int   acc_cyc = 0;
    logic busy_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !busy_prev) acc_cyc = cyc;
            busy_prev = busy;
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb_q.pop_front();
                    txn++;
                    $display("txn %0d rnw=%0b dev=%h reg=%h err_nack=%0b err_to=%0b rdata=%h cmds=%0d",
                             txn, e.rnw, e.dev, e.reg_a, err_nack, err_to, rdata, cmd_log.size());
                    chk("err_nack", 13'(err_nack), 13'(e.err_nack));
                    chk("err_to", 13'(err_to), 13'(e.err_to));
                    chk("busy_at_done", 13'(busy), 13'd0);
                    chk("cmds_idle_at_done", {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}, 13'd0);
                    chk("cmd_count", 13'(cmd_log.size()), 13'(e.ncmd));
                    for (int i = 0; i < int'(e.ncmd) && i < cmd_log.size(); i++)
                        chk($sformatf("cmd%0d", i), cmd_log[i], e.cmds[i]);
                    if (e.chk_rdata) chk("rdata", 13'(rdata), 13'(e.rdata));
                    if (e.lat != 8'd0) chk("timeout_latency", 13'(cyc - acc_cyc), 13'(e.lat));
                    cmd_log.delete();
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 13'(busy), 13'd0);
        chk({tag, "_done"}, 13'(done), 13'd0);
        chk({tag, "_rdata"}, 13'(rdata), 13'd0);
        chk({tag, "_errs"}, 13'({err_nack, err_to}), 13'd0);
        chk({tag, "_cmds"}, {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}, 13'd0);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
        exp_t e;
        model_req(r, d, ra, wd, e);
        @(negedge clk);
        rnw = r; dev_addr = d; reg_addr = ra; wdata = wd; req = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        req = 1'b0;
        wait_drain(200);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t e1, e2;
        int   n;
        rst = 1'b1; req = 1'b0; rnw = 1'b0; dev_addr = 7'h00; reg_addr = 8'h00; wdata = 8'h00;
        mute = 1'b0; nack_data = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(I2C_RW_WRITE, 7'h50, 8'h12, 8'hA5);
        mem[8'h34] = 8'h5C;
        ref_mem[8'h34] = 8'h5C;
        issue(I2C_RW_READ, 7'h50, 8'h34, 8'h00);
        issue(I2C_RW_WRITE, 7'h27, 8'h12, 8'h33);
        nack_data = 1'b1;
        issue(I2C_RW_WRITE, 7'h50, 8'h40, 8'h77);
        nack_data = 1'b0;
        mute = 1'b1;
        issue(I2C_RW_WRITE, 7'h50, 8'h01, 8'h02);
        mute = 1'b0;

        // Reset while the register byte is on the bus, then two back-to-back requests.
        @(negedge clk);
        rnw = I2C_RW_WRITE; dev_addr = 7'h50; reg_addr = 8'h66; wdata = 8'h11; req = 1'b1;
        n = 0;
        while (!(bc_write && !bc_start && bc_din == 8'h66) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_reg_state", 13'(n < 50), 13'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        model_req(I2C_RW_WRITE, 7'h50, 8'h66, 8'h11, e1);
        model_req(I2C_RW_WRITE, 7'h50, 8'h66, 8'h11, e2);
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        rst = 1'b0;
        n = 0;
        while (sb_q.size() > 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (!busy && n < 220) begin
            @(negedge clk);
            n++;
        end
        chk("second_accept", 13'(busy), 13'd1);
        req = 1'b0;
        wait_drain(200);
        repeat (20) @(negedge clk);

        for (int t = 0; t < 24; t++) begin
            logic       r;
            logic [6:0] d;
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: d = 7'h50;
                1: d = 7'h3C;
                2: d = 7'h27;
                default: d = 7'($urandom);
            endcase
            nack_data = ($urandom_range(0, 4) == 0);
            mute      = ($urandom_range(0, 7) == 0);
            issue(r, d, 8'($urandom_range(0, 7)), 8'($urandom));
            mute      = 1'b0;
            nack_data = 1'b0;
        end

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
